hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline hazard and stall controller for the 5-stage RV32IC core. It detects hazards that forwarding cannot cover:
//  load-use in EX, and jalr in ID reading rs1 that is not yet forwardable.
//  It is the stall/flush counterpart of the forwarding logic.
//  It tracks in-flight destinations in a private shadow pipeline (EX, MEM).
//  It drives PC/IF-ID write enables, ID-EX bubble, branch flushes, and global freeze on data-memory stall.
// PARAMETERS
//  CNT_W        16   width of saturating performance counters
// PORTS
//  clk_i               in   1      core clock
//  rst_i               in   1      synchronous reset, active-high
//  RS1addr_ID_i        in   5      rs1 of instruction in ID
//  RS2addr_ID_i        in   5      rs2 of instruction in ID
//  UseRS1_ID_i         in   1      ID instruction reads rs1
//  UseRS2_ID_i         in   1      ID instruction reads rs2
//  IsJalr_ID_i         in   1      ID instruction is jalr (target computed in ID)
//  RDaddr_ID_i         in   5      rd of ID instruction
//  RegWrite_ID_i       in   1      ID instruction writes rd
//  MemRead_ID_i        in   1      ID instruction is a load
//  BranchTaken_EX_i    in   1      branch resolved taken in EX
//  MemStall_i          in   1      data memory not ready; freeze pipeline
//  PCWrite_o           out  1      PC update enable
//  IFIDWrite_o         out  1      IF/ID register enable
//  IDEXBubble_o        out  1      insert NOP into ID/EX
//  IFIDFlush_o         out  1      clear IF/ID (branch taken)
//  Freeze_o            out  1      hold ID/EX, EX/MEM, MEM/WB
//  StallReason_o       out  2      0 none, 1 load-use, 2 jalr-rs1, 3 mem-stall
//  StallCnt_o          out  CNT_W  hazard stall cycles, saturating
//  FlushCnt_o          out  CNT_W  branch flush events, saturating
// BEHAVIOUR
//  Reset (rst_i high at posedge): shadow EX/MEM entries cleared (rd=0, wr=0, ld=0), counters 0.
//  While rst_i high: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, IFIDFlush_o=0, Freeze_o=0, StallReason_o=0.
//  Shadow entry = {rd[4:0], wr, ld}. An entry with rd==0 never matches anything.
//  Hazard terms, combinational from the registered shadow and the ID inputs:
//   LU = ex.ld & ex.rd!=0 & ((UseRS1 & RS1==ex.rd) | (UseRS2 & RS2==ex.rd))
//   JR = IsJalr & RS1!=0 & ((ex.wr & RS1==ex.rd) | (mem.ld & RS1==mem.rd))
//   HZ = LU | JR. When both hold, StallReason_o=1.
//  Priority, one decision per cycle: MemStall_i > BranchTaken_EX_i > HZ > run.
//   MemStall: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=0, IFIDFlush_o=0, reason 3; shadow holds.
//   Branch:   PCWrite_o=1, IFIDFlush_o=1, IDEXBubble_o=1 (kills the ID instruction); HZ ignored.
//             Shadow: mem<=ex, ex<=0. FlushCnt_o += 1.
//   HZ:       PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, reason 1/2.
//             Shadow: mem<=ex, ex<=0. StallCnt_o += 1.
//   Run:      all enables 1, bubble/flush/freeze 0, reason 0.
//             Shadow: mem<=ex, ex<={RDaddr_ID, RegWrite_ID, MemRead_ID}.
//  Latency: outputs are combinational, in the same cycle as the inputs. The shadow updates at posedge.
//  Load-use stalls exactly 1 cycle.
//  jalr after an ALU producer stalls 1 cycle; the value then forwards from EX/MEM.
//  jalr after a load stalls 2 cycles: cycle 1 on ex.wr, cycle 2 on mem.ld.
//  MemStall during a hazard stall freezes everything. Stall resumes after release; the stall count is unchanged.
//  BranchTaken held across MemStall is acted on in the first unstalled cycle, exactly once.
//  Counters saturate at all-ones and do not wrap. Synchronous reset mid-stall aborts it; the next cycle is run.
// STRUCTURE
//  hazard_defs.vh: StallReason encodings and shadow entry field offsets/width (7 bits).
//  Sub-module hazard_shadow_stage: one 7-bit entry register with load/clear/hold controls.
//   Instantiated twice, as EX and MEM.
//  Top level holds the priority decode and the two counters.
// TESTING
//  1 lw x5 then add x6,x5,x1 -> one cycle PCWrite_o=0, IDEXBubble_o=1, reason 1; StallCnt_o=1; then run.
//  2 addi x7 then jalr x0,0(x7) -> 1 stall, reason 2; next cycle run.
//  3 lw x7 then jalr x0,0(x7) -> 2 stall cycles, reason 2, StallCnt_o=2.
//  4 BranchTaken_EX_i=1 with load-use pending in ID -> IFIDFlush_o=1, PCWrite_o=1, no stall; FlushCnt_o=1.
//  5 MemStall_i high 3 cycles during load-use stall -> Freeze_o=1, reason 3 x3, then 1 stall; StallCnt_o=1.
//  6 rd=x0 load then use of x0 -> no stall.
//  7 Preload StallCnt_o near max, force 2 stalls -> saturates at 0xFFFF.
//  8 rst_i high mid-stall -> reset values; next cycle run.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard/stall controller: shadow pipeline entry layout,
// stall reason encodings and the per-cycle pipeline decision.
package hazard_control_unit_pkg;

    localparam int RegAddrW = 5;
    localparam int EntryW   = 7;

    typedef enum logic [1:0] {
        ReasonNone     = 2'd0,
        ReasonLoadUse  = 2'd1,
        ReasonJalr     = 2'd2,
        ReasonMemStall = 2'd3
    } stallReason_e;

    // {rd, wr, ld}: destination register, writes rd, is a load
    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic                wr;
        logic                ld;
    } shadowEntry_t;

    localparam shadowEntry_t EmptyEntry = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};

    typedef enum logic [1:0] {
        DecRun,
        DecHazard,
        DecBranch,
        DecFreeze
    } decision_e;

    // x0 is never a real producer, so an entry with rd==0 never matches.
    function automatic logic entryHits(input shadowEntry_t e, input logic [RegAddrW-1:0] addr);
        return (e.rd != 5'd0) && (e.rd == addr);
    endfunction

endpackage

// File: rtl/hazard_control_unit_shadow_stage.sv
// One slot of the private destination-tracking pipeline (used as EX and MEM).
// Reset or clear empties the slot; load captures a new entry; otherwise it holds.
module hazard_shadow_stage
    import hazard_control_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         loadEn,
    input  logic         clearEn,
    input  shadowEntry_t entryD,
    output shadowEntry_t entryQ
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clearEn) begin
            entryQ <= EmptyEntry;
        end else if (loadEn) begin
            entryQ <= entryD;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: detects load-use and jalr-rs1 hazards from a shadow of
// the EX/MEM destinations, prioritises mem-stall > branch > hazard > run.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       RS1addr_ID_i,
    input  logic [4:0]       RS2addr_ID_i,
    input  logic             UseRS1_ID_i,
    input  logic             UseRS2_ID_i,
    input  logic             IsJalr_ID_i,
    input  logic [4:0]       RDaddr_ID_i,
    input  logic             RegWrite_ID_i,
    input  logic             MemRead_ID_i,
    input  logic             BranchTaken_EX_i,
    input  logic             MemStall_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IDEXBubble_o,
    output logic             IFIDFlush_o,
    output logic             Freeze_o,
    output logic [1:0]       StallReason_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o,
    output shadowEntry_t     ShadowEX_o,
    output shadowEntry_t     ShadowMEM_o
);

    shadowEntry_t exEntry;
    shadowEntry_t memEntry;
    shadowEntry_t idEntry;
    logic         loadUse;
    logic         jalrHazard;
    logic         advance;
    decision_e    decision;

    always_comb begin
        loadUse    = exEntry.ld &
                     ((UseRS1_ID_i & entryHits(exEntry, RS1addr_ID_i)) |
                      (UseRS2_ID_i & entryHits(exEntry, RS2addr_ID_i)));
        // jalr needs rs1 in ID: an EX producer is not forwardable yet, nor is a load in MEM
        jalrHazard = IsJalr_ID_i &
                     ((exEntry.wr & entryHits(exEntry, RS1addr_ID_i)) |
                      (memEntry.ld & entryHits(memEntry, RS1addr_ID_i)));
        if (MemStall_i) begin
            decision = DecFreeze;
        end else if (BranchTaken_EX_i) begin
            decision = DecBranch;
        end else if (loadUse || jalrHazard) begin
            decision = DecHazard;
        end else begin
            decision = DecRun;
        end
    end

    always_comb begin
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IDEXBubble_o  = 1'b0;
        IFIDFlush_o   = 1'b0;
        Freeze_o      = 1'b0;
        StallReason_o = ReasonNone;
        case (decision)
            DecFreeze: begin
                PCWrite_o     = 1'b0;
                IFIDWrite_o   = 1'b0;
                Freeze_o      = 1'b1;
                StallReason_o = ReasonMemStall;
            end
            DecBranch: begin
                IFIDFlush_o  = 1'b1;
                IDEXBubble_o = 1'b1;
            end
            DecHazard: begin
                PCWrite_o     = 1'b0;
                IFIDWrite_o   = 1'b0;
                IDEXBubble_o  = 1'b1;
                StallReason_o = loadUse ? ReasonLoadUse : ReasonJalr;
            end
            default: ;
        endcase
        if (rst_i) begin
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IDEXBubble_o  = 1'b1;
            IFIDFlush_o   = 1'b0;
            Freeze_o      = 1'b0;
            StallReason_o = ReasonNone;
        end
    end

    assign advance = !rst_i && (decision != DecFreeze);
    assign idEntry = '{rd: RDaddr_ID_i, wr: RegWrite_ID_i, ld: MemRead_ID_i};

    hazard_shadow_stage exStage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .loadEn  (advance && (decision == DecRun)),
        .clearEn (advance && (decision == DecBranch || decision == DecHazard)),
        .entryD  (idEntry),
        .entryQ  (exEntry)
    );

    hazard_shadow_stage memStage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .loadEn  (advance),
        .clearEn (1'b0),
        .entryD  (exEntry),
        .entryQ  (memEntry)
    );

    assign ShadowEX_o  = exEntry;
    assign ShadowMEM_o = memEntry;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            StallCnt_o <= '0;
            FlushCnt_o <= '0;
        end else begin
            if (decision == DecHazard && StallCnt_o != {CNT_W{1'b1}}) begin
                StallCnt_o <= StallCnt_o + CNT_W'(1);
            end
            if (decision == DecBranch && FlushCnt_o != {CNT_W{1'b1}}) begin
                FlushCnt_o <= FlushCnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: each vector pushes its expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    localparam int W = 43;
    // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Freeze}
    localparam logic [4:0] RUN = 5'b11000;
    localparam logic [4:0] STL = 5'b00100;
    localparam logic [4:0] BRN = 5'b11110;
    localparam logic [4:0] FRZ = 5'b00001;
    localparam logic [4:0] RST = 5'b00100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       use1 = 1'b0, use2 = 1'b0, isJalr = 1'b0, regWrite = 1'b0, memRead = 1'b0;
    logic       branch = 1'b0, memStall = 1'b0;

    logic         pcWrite, ifidWrite, bubble, flush, freeze;
    logic [1:0]   reason;
    logic [15:0]  stallCnt, flushCnt;
    shadowEntry_t shEx, shMem;

    logic         smPc, smIfid, smBub, smFlush, smFreeze;
    logic [1:0]   smReason;
    logic [3:0]   smStall, smFlushCnt;
    shadowEntry_t smEx, smMem;

    hazard_control_unit #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2), .UseRS1_ID_i(use1), .UseRS2_ID_i(use2),
        .IsJalr_ID_i(isJalr), .RDaddr_ID_i(rd), .RegWrite_ID_i(regWrite), .MemRead_ID_i(memRead),
        .BranchTaken_EX_i(branch), .MemStall_i(memStall),
        .PCWrite_o(pcWrite), .IFIDWrite_o(ifidWrite), .IDEXBubble_o(bubble), .IFIDFlush_o(flush),
        .Freeze_o(freeze), .StallReason_o(reason), .StallCnt_o(stallCnt), .FlushCnt_o(flushCnt),
        .ShadowEX_o(shEx), .ShadowMEM_o(shMem)
    );

    // Narrow-counter copy so saturation is reachable in a short run
    hazard_control_unit #(.CNT_W(4)) dutSmall (
        .clk_i(clk), .rst_i(rst),
        .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2), .UseRS1_ID_i(use1), .UseRS2_ID_i(use2),
        .IsJalr_ID_i(isJalr), .RDaddr_ID_i(rd), .RegWrite_ID_i(regWrite), .MemRead_ID_i(memRead),
        .BranchTaken_EX_i(branch), .MemStall_i(memStall),
        .PCWrite_o(smPc), .IFIDWrite_o(smIfid), .IDEXBubble_o(smBub), .IFIDFlush_o(smFlush),
        .Freeze_o(smFreeze), .StallReason_o(smReason), .StallCnt_o(smStall), .FlushCnt_o(smFlushCnt),
        .ShadowEX_o(smEx), .ShadowMEM_o(smMem)
    );

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    int           expStall = 0, expFlush = 0, expSmall = 0;

    task automatic step(input string tag, input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2, input logic jr, input logic [4:0] d,
                        input logic rw, input logic mr, input logic br, input logic ms,
                        input logic [4:0] ctl, input logic [1:0] rsn, input bit chk);
        @(posedge clk);
        #1;
        rst = r; rs1 = a1; rs2 = a2; use1 = u1; use2 = u2; isJalr = jr;
        rd = d; regWrite = rw; memRead = mr; branch = br; memStall = ms;
        if (chk) begin
            exp_q.push_back({ctl, rsn, 16'(expStall), 16'(expFlush), 4'(expSmall)});
            tag_q.push_back(tag);
        end
        if (r) begin
            expStall = 0; expFlush = 0; expSmall = 0;
        end else if (ctl[1]) begin
            if (expFlush < 65535) expFlush++;
        end else if (rsn == 2'd1 || rsn == 2'd2) begin
            if (expStall < 65535) expStall++;
            if (expSmall < 15) expSmall++;
        end
    endtask

    // lw xd, 0(x1)
    task automatic lw(input string tag, input logic [4:0] d);
        step(tag, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0, RUN, 2'd0, 1'b1);
    endtask

    // add x6, xsrc, x1
    task automatic add(input string tag, input logic [4:0] src, input logic br, input logic ms,
                       input logic [4:0] ctl, input logic [1:0] rsn);
        step(tag, 1'b0, src, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, br, ms, ctl, rsn, 1'b1);
    endtask

    // jalr x0, 0(xsrc)
    task automatic jalr(input string tag, input logic [4:0] src, input logic u1, input logic r,
                        input logic [4:0] ctl, input logic [1:0] rsn);
        step(tag, r, src, 5'd0, u1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, rsn, 1'b1);
    endtask

    logic [W-1:0] monExp, monAct;
    string        monTag;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            monExp = exp_q.pop_front();
            monTag = tag_q.pop_front();
            monAct = {pcWrite, ifidWrite, bubble, flush, freeze, reason, stallCnt, flushCnt, smStall};
            checks++;
            if (monAct !== monExp) begin
                errors++;
                $display("FAIL %s: got ctl=%b rsn=%0d stall=%h flush=%h small=%h, want ctl=%b rsn=%0d stall=%h flush=%h small=%h",
                         monTag, monAct[42:38], monAct[37:36], monAct[35:20], monAct[19:4], monAct[3:0],
                         monExp[42:38], monExp[37:36], monExp[35:20], monExp[19:4], monExp[3:0]);
            end
        end
    end

    initial begin
        step("rst0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 2'd0, 1'b0);
        step("rst1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 2'd0, 1'b1);

        lw  ("lu_lw", 5'd5);
        add ("lu_stall", 5'd5, 1'b0, 1'b0, STL, 2'd1);
        add ("lu_run", 5'd5, 1'b0, 1'b0, RUN, 2'd0);

        step("alu_addi", 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 2'd0, 1'b1);
        jalr("alu_jr_stall", 5'd7, 1'b1, 1'b0, STL, 2'd2);
        jalr("alu_jr_run", 5'd7, 1'b1, 1'b0, RUN, 2'd0);

        lw  ("ld_jr_lw", 5'd7);
        jalr("ld_jr_stall1", 5'd7, 1'b0, 1'b0, STL, 2'd2);
        jalr("ld_jr_stall2", 5'd7, 1'b0, 1'b0, STL, 2'd2);
        jalr("ld_jr_run", 5'd7, 1'b0, 1'b0, RUN, 2'd0);

        // jalr that also flags UseRS1: load-use and jalr both hold, load-use reported
        lw  ("tie_lw", 5'd7);
        jalr("tie_stall1", 5'd7, 1'b1, 1'b0, STL, 2'd1);
        jalr("tie_stall2", 5'd7, 1'b1, 1'b0, STL, 2'd2);
        jalr("tie_run", 5'd7, 1'b1, 1'b0, RUN, 2'd0);

        lw  ("br_lw", 5'd5);
        add ("br_flush", 5'd5, 1'b1, 1'b0, BRN, 2'd0);
        add ("br_after", 5'd5, 1'b0, 1'b0, RUN, 2'd0);

        lw  ("ms_lw", 5'd5);
        for (int i = 0; i < 3; i++) add("ms_freeze", 5'd5, 1'b0, 1'b1, FRZ, 2'd3);
        add ("ms_stall", 5'd5, 1'b0, 1'b0, STL, 2'd1);
        add ("ms_run", 5'd5, 1'b0, 1'b0, RUN, 2'd0);

        lw  ("msbr_lw", 5'd5);
        add ("msbr_freeze1", 5'd5, 1'b1, 1'b1, FRZ, 2'd3);
        add ("msbr_freeze2", 5'd5, 1'b1, 1'b1, FRZ, 2'd3);
        add ("msbr_flush", 5'd5, 1'b1, 1'b0, BRN, 2'd0);
        add ("msbr_run", 5'd5, 1'b0, 1'b0, RUN, 2'd0);

        step("x0_lw", 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, RUN, 2'd0, 1'b1);
        add ("x0_use", 5'd0, 1'b0, 1'b0, RUN, 2'd0);

        lw  ("rst_lw", 5'd7);
        jalr("rst_stall1", 5'd7, 1'b0, 1'b0, STL, 2'd2);
        jalr("rst_mid", 5'd7, 1'b0, 1'b1, RST, 2'd0);
        jalr("rst_after", 5'd7, 1'b0, 1'b0, RUN, 2'd0);

        for (int i = 0; i < 16; i++) begin
            lw ("sat_lw", 5'd5);
            add("sat_stall", 5'd5, 1'b0, 1'b0, STL, 2'd1);
        end
        add ("sat_final", 5'd1, 1'b0, 1'b0, RUN, 2'd0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
